// File: rtl/bit_deserializer_if.sv
// bit_deserializer_if: bit-stream pop port and word-output rdy/en port bundle
interface bit_deserializer_if #(parameter int WIDTH = 8);
  logic in_rdy;
  logic in_data;
  logic in_en;
  logic out_rdy;
  logic out_en;
  logic flush;
  logic [WIDTH-1:0] out_data;
  logic [$clog2(WIDTH+1)-1:0] out_bits;
  modport slave (input in_rdy, in_data, out_en, flush, output in_en, out_rdy, out_data, out_bits);
  modport master (output in_rdy, in_data, out_en, flush, input in_en, out_rdy, out_data, out_bits);
endinterface

// File: rtl/bit_deserializer.sv
// bit_deserializer: packs LSB-first bits into WIDTH-bit words with flush of partial words
module bit_deserializer #(parameter int WIDTH = 8) (
  input logic CLK,
  input logic RST_N,
  bit_deserializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [WIDTH-1:0] sh_q, sh_d, sh_w, dat_q, dat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bits_q, bits_d;
  logic full_q, full_d, ofree, acc, fl, load;
  assign ofree = !full_q || bus.out_en;
  assign acc = RST_N && bus.in_rdy && !bus.flush && (cnt_q != LAST || ofree);
  assign fl = bus.flush && cnt_q != '0 && ofree;
  assign load = (acc && cnt_q == LAST) || fl;
  assign bus.in_en = acc;
  assign bus.out_rdy = full_q;
  assign bus.out_data = dat_q;
  assign bus.out_bits = bits_q;
  // Next state: insert accepted bit, close a word on the last bit or on flush; sh stays zero above cnt
  always_comb begin
    sh_w = sh_q;
    sh_w[cnt_q] = bus.in_data;
    sh_d = load ? '0 : acc ? sh_w : sh_q;
    cnt_d = load ? '0 : acc ? cnt_q + 1'b1 : cnt_q;
    dat_d = load ? (fl ? sh_q : sh_w) : dat_q;
    bits_d = load ? (fl ? BW'(cnt_q) : BW'(WIDTH)) : bits_q;
    full_d = load || (full_q && !bus.out_en);
  end
  // State registers; reset discards partial and held words
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sh_q <= '0;
      cnt_q <= '0;
      dat_q <= '0;
      bits_q <= '0;
      full_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      dat_q <= dat_d;
      bits_q <= bits_d;
      full_q <= full_d;
    end
  end
endmodule

// File: tb/tb_bit_deserializer.sv
// tb_bit_deserializer: scenario tasks plus randomized run against a queue-based word model
module tb_bit_deserializer;
  localparam int W = 8;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int checks = 0;
  int failures = 0;
  bit wq[$];
  logic [W-1:0] mdata = '0;
  logic [3:0] mbits = '0;
  bit mfull = 1'b0;
  bit_deserializer_if #(.WIDTH(W)) bus ();
  bit_deserializer #(.WIDTH(W)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  always #5 CLK = ~CLK;
  function automatic bit model_en();
    return RST_N && bus.in_rdy && !bus.flush && (wq.size() != W - 1 || !mfull || bus.out_en);
  endfunction
  function automatic logic [W-1:0] pack();
    logic [W-1:0] v = '0;
    for (int k = 0; k < wq.size(); k++) v[k] = wq[k];
    return v;
  endfunction
  task automatic mreset();
    wq.delete();
    mdata = '0;
    mbits = '0;
    mfull = 1'b0;
  endtask
  task automatic tick();
    bit ld = 1'b0;
    if (model_en()) begin
      wq.push_back(bus.in_data);
      if (wq.size() == W) begin
        mdata = pack();
        mbits = 4'(W);
        ld = 1'b1;
        wq.delete();
      end
    end else if (bus.flush && wq.size() > 0 && (!mfull || bus.out_en)) begin
      mdata = pack();
      mbits = 4'(wq.size());
      ld = 1'b1;
      wq.delete();
    end
    if (ld) mfull = 1'b1;
    else if (bus.out_en) mfull = 1'b0;
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(input bit r, input bit d, input bit f, input bit o);
    bus.in_rdy = r;
    bus.in_data = d;
    bus.flush = f;
    bus.out_en = o;
    #1;
  endtask
  task automatic feed(input bit b);
    drive(1'b1, b, 1'b0, 1'b0);
    tick();
  endtask
  task automatic test_reset();
    bus.in_rdy = 1'b1;
    bus.in_data = 1'b1;
    bus.flush = 1'b0;
    bus.out_en = 1'b0;
    mreset();
    #23;
    checks++; if (bus.in_en !== 1'b0) begin failures++; $display("FAIL reset_in_en got=%b exp=0", bus.in_en); end
    checks++; if (bus.out_rdy !== 1'b0) begin failures++; $display("FAIL reset_out_rdy got=%b exp=0", bus.out_rdy); end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
    checks++; if (bus.out_bits !== 4'd0) begin failures++; $display("FAIL reset_out_bits got=%0d exp=0", bus.out_bits); end
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    checks++; if (bus.in_en !== 1'b1) begin failures++; $display("FAIL release_in_en got=%b exp=1", bus.in_en); end
  endtask
  task automatic test_basic();
    bit pat[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, pat[i], 1'b0, 1'b0);
      checks++; if (bus.in_en !== 1'b1) begin failures++; $display("FAIL basic_in_en bit=%0d got=%b exp=1", i, bus.in_en); end
      if (i < 7) begin
        checks++; if (bus.out_rdy !== 1'b0) begin failures++; $display("FAIL basic_early_rdy bit=%0d got=%b exp=0", i, bus.out_rdy); end
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.out_rdy !== 1'b1) begin failures++; $display("FAIL basic_out_rdy got=%b exp=1", bus.out_rdy); end
    checks++; if (bus.out_data !== 8'h4D) begin failures++; $display("FAIL basic_out_data got=%h exp=4d", bus.out_data); end
    checks++; if (bus.out_bits !== 4'd8) begin failures++; $display("FAIL basic_out_bits got=%0d exp=8", bus.out_bits); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.out_rdy !== 1'b0) begin failures++; $display("FAIL basic_pop_rdy got=%b exp=0", bus.out_rdy); end
    checks++; if (bus.out_data !== 8'h4D) begin failures++; $display("FAIL basic_pop_keep got=%h exp=4d", bus.out_data); end
  endtask
  task automatic test_backpressure();
    bit pat[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) feed(pat[i]);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      checks++; if (bus.in_en !== 1'b1) begin failures++; $display("FAIL bp_accept bit=%0d got=%b exp=1", i, bus.in_en); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      checks++; if (bus.in_en !== 1'b0) begin failures++; $display("FAIL bp_stall cyc=%0d got=%b exp=0", i, bus.in_en); end
      checks++; if (bus.out_data !== 8'h4D) begin failures++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=4d", i, bus.out_data); end
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (bus.in_en !== 1'b1) begin failures++; $display("FAIL bp_release_in_en got=%b exp=1", bus.in_en); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.out_rdy !== 1'b1) begin failures++; $display("FAIL bp_out_rdy got=%b exp=1", bus.out_rdy); end
    checks++; if (bus.out_data !== 8'hFF) begin failures++; $display("FAIL bp_out_data got=%h exp=ff", bus.out_data); end
    checks++; if (bus.out_bits !== 4'd8) begin failures++; $display("FAIL bp_out_bits got=%0d exp=8", bus.out_bits); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask
  task automatic test_flush();
    feed(1'b1);
    feed(1'b1);
    feed(1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.in_en !== 1'b0) begin failures++; $display("FAIL flush_in_en got=%b exp=0", bus.in_en); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.out_rdy !== 1'b1) begin failures++; $display("FAIL flush_out_rdy got=%b exp=1", bus.out_rdy); end
    checks++; if (bus.out_data !== 8'h03) begin failures++; $display("FAIL flush_out_data got=%h exp=03", bus.out_data); end
    checks++; if (bus.out_bits !== 4'd3) begin failures++; $display("FAIL flush_out_bits got=%0d exp=3", bus.out_bits); end
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.out_rdy !== 1'b0) begin failures++; $display("FAIL flush_empty_rdy got=%b exp=0", bus.out_rdy); end
    checks++; if (bus.out_bits !== 4'd3) begin failures++; $display("FAIL flush_empty_bits got=%0d exp=3", bus.out_bits); end
  endtask
  task automatic test_flush_blocked();
    logic [W-1:0] v;
    v = W'($urandom);
    for (int i = 0; i < W; i++) feed(v[i]);
    feed(1'b1);
    feed(1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      checks++; if (bus.in_en !== 1'b0) begin failures++; $display("FAIL fb_in_en cyc=%0d got=%b exp=0", i, bus.in_en); end
      tick();
      checks++; if (bus.out_data !== v || bus.out_rdy !== 1'b1) begin failures++; $display("FAIL fb_hold cyc=%0d got=%h/%b exp=%h/1", i, bus.out_data, bus.out_rdy, v); end
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.out_rdy !== 1'b1) begin failures++; $display("FAIL fb_out_rdy got=%b exp=1", bus.out_rdy); end
    checks++; if (bus.out_bits !== 4'd2) begin failures++; $display("FAIL fb_out_bits got=%0d exp=2", bus.out_bits); end
    checks++; if (bus.out_data !== 8'h01) begin failures++; $display("FAIL fb_out_data got=%h exp=01", bus.out_data); end
  endtask
  task automatic test_reset_mid();
    bit pat[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) feed(1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    RST_N = 1'b0;
    mreset();
    #1;
    checks++; if (bus.out_rdy !== 1'b0) begin failures++; $display("FAIL rm_out_rdy got=%b exp=0", bus.out_rdy); end
    checks++; if (bus.in_en !== 1'b0) begin failures++; $display("FAIL rm_in_en got=%b exp=0", bus.in_en); end
    RST_N = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) feed(pat[i]);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.out_data !== 8'h80) begin failures++; $display("FAIL rm_out_data got=%h exp=80", bus.out_data); end
    checks++; if (bus.out_bits !== 4'd8) begin failures++; $display("FAIL rm_out_bits got=%0d exp=8", bus.out_bits); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask
  task automatic test_random();
    bit e;
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0, 1'($urandom));
      e = model_en();
      checks++; if (bus.in_en !== e) begin failures++; $display("FAIL rnd_in_en cyc=%0d got=%b exp=%b", i, bus.in_en, e); end
      tick();
      checks++; if (bus.out_rdy !== mfull) begin failures++; $display("FAIL rnd_out_rdy cyc=%0d got=%b exp=%b", i, bus.out_rdy, mfull); end
      checks++; if (bus.out_data !== mdata || bus.out_bits !== mbits) begin failures++; $display("FAIL rnd_word cyc=%0d got=%h/%0d exp=%h/%0d", i, bus.out_data, bus.out_bits, mdata, mbits); end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_flush_blocked();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
